// File: rtl/controle_jogada.sv
// Move-commit controller for tic-tac-toe: validates a requested cell, writes the
// current player's mark, detects win/draw and pulses the player-turn toggle.
module controle_jogada #(
    parameter int unsigned N_CASAS = 9
) (
    input  logic                   clk,
    input  logic                   clear_n,
    input  logic                   novo_jogo,
    input  logic [1:0]             jogador,
    input  logic                   jogada_valid,
    input  logic [3:0]             jogada_pos,
    output logic                   jogada_ready,
    output logic                   troca_jogador,
    output logic                   jogada_invalida,
    output logic [2*N_CASAS-1:0]   tabuleiro,
    output logic [1:0]             vencedor,
    output logic                   empate,
    output logic                   fim_jogo
);

    localparam int unsigned W_POS = 4;
    localparam int unsigned W_JOG = 2;
    localparam int unsigned W_CNT = 4;
    localparam int unsigned W_TAB = 2 * N_CASAS;

    typedef enum logic [2:0] {
        ESPERA,
        VERIFICA,
        ESCREVE,
        AVALIA,
        TROCA,
        INVALIDA,
        FIM
    } estado_t;

    estado_t            estado;
    estado_t            estado_next;
    logic [W_POS-1:0]   pos_q;
    logic [W_JOG-1:0]   jog_q;
    logic [W_CNT-1:0]   cnt;
    logic               captura;
    logic               escreve;
    logic               marca_vitoria;
    logic               marca_empate;

    // Contents of one cell; positions beyond the board read as empty.
    function automatic logic [W_JOG-1:0] casa(input logic [W_TAB-1:0] tab,
                                              input logic [W_POS-1:0] pos);
        casa = 2'b00;
        for (int i = 0; i < int'(N_CASAS); i++) begin
            if (pos == W_POS'(i)) casa = tab[2*i +: 2];
        end
    endfunction

    function automatic logic tres(input logic [W_JOG-1:0] a, input logic [W_JOG-1:0] b,
                                  input logic [W_JOG-1:0] c, input logic [W_JOG-1:0] p);
        tres = (a == p) && (b == p) && (c == p);
    endfunction

    // Rows, columns and both diagonals of the 3x3 board.
    function automatic logic venceu(input logic [W_TAB-1:0] tab, input logic [W_JOG-1:0] p);
        logic [W_JOG-1:0] c [9];
        for (int i = 0; i < 9; i++) c[i] = tab[2*i +: 2];
        venceu = tres(c[0], c[1], c[2], p) || tres(c[3], c[4], c[5], p) ||
                 tres(c[6], c[7], c[8], p) || tres(c[0], c[3], c[6], p) ||
                 tres(c[1], c[4], c[7], p) || tres(c[2], c[5], c[8], p) ||
                 tres(c[0], c[4], c[8], p) || tres(c[2], c[4], c[6], p);
    endfunction

    // Next-state and datapath strobes.
    always_comb begin
        estado_next   = estado;
        captura       = 1'b0;
        escreve       = 1'b0;
        marca_vitoria = 1'b0;
        marca_empate  = 1'b0;
        case (estado)
            ESPERA: begin
                if (jogada_valid) begin
                    captura     = 1'b1;
                    estado_next = VERIFICA;
                end
            end
            VERIFICA: begin
                if ((pos_q > W_POS'(N_CASAS - 1)) || (casa(tabuleiro, pos_q) != 2'b00) ||
                    (jog_q == 2'b00) || (jog_q == 2'b11))
                    estado_next = INVALIDA;
                else
                    estado_next = ESCREVE;
            end
            ESCREVE: begin
                escreve     = 1'b1;
                estado_next = AVALIA;
            end
            AVALIA: begin
                if (venceu(tabuleiro, jog_q)) begin
                    marca_vitoria = 1'b1;
                    estado_next   = FIM;
                end else if (cnt == W_CNT'(N_CASAS)) begin
                    marca_empate = 1'b1;
                    estado_next  = FIM;
                end else begin
                    estado_next = TROCA;
                end
            end
            TROCA:    estado_next = ESPERA;
            INVALIDA: estado_next = ESPERA;
            FIM:      estado_next = FIM;
            default:  estado_next = ESPERA;
        endcase
        // New game wins over any transition or handshake this cycle.
        if (novo_jogo) begin
            estado_next   = ESPERA;
            captura       = 1'b0;
            escreve       = 1'b0;
            marca_vitoria = 1'b0;
            marca_empate  = 1'b0;
        end
    end

    // State register with Moore outputs registered from the next state.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            estado          <= ESPERA;
            jogada_ready    <= 1'b1;
            troca_jogador   <= 1'b0;
            jogada_invalida <= 1'b0;
        end else begin
            estado          <= estado_next;
            jogada_ready    <= (estado_next == ESPERA);
            troca_jogador   <= (estado_next == TROCA);
            jogada_invalida <= (estado_next == INVALIDA);
        end
    end

    // Board, move counter, latched request and result flags.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            pos_q     <= '0;
            jog_q     <= '0;
            cnt       <= '0;
            tabuleiro <= '0;
            vencedor  <= '0;
            empate    <= 1'b0;
            fim_jogo  <= 1'b0;
        end else if (novo_jogo) begin
            pos_q     <= '0;
            jog_q     <= '0;
            cnt       <= '0;
            tabuleiro <= '0;
            vencedor  <= '0;
            empate    <= 1'b0;
            fim_jogo  <= 1'b0;
        end else begin
            if (captura) begin
                pos_q <= jogada_pos;
                jog_q <= jogador;
            end
            if (escreve) begin
                for (int i = 0; i < int'(N_CASAS); i++) begin
                    if (pos_q == W_POS'(i)) tabuleiro[2*i +: 2] <= jog_q;
                end
                cnt <= cnt + W_CNT'(1);
            end
            if (marca_vitoria) begin
                vencedor <= jog_q;
                fim_jogo <= 1'b1;
            end
            if (marca_empate) begin
                empate   <= 1'b1;
                fim_jogo <= 1'b1;
            end
        end
    end

endmodule

// File: doc/controle_jogada.md
Name: controle_jogada

Overview:
Move-commit controller for the tic-tac-toe datapath, and the driving end of the player-turn toggle. It accepts a board position from the input/keypad logic with a valid/ready handshake and validates it against the 3x3 board it holds. Each legal move is written with the current player code, checked for a win or draw, and answered with a one-cycle `troca_jogador` pulse. That pulse feeds the T input of the player-turn flip-flop, whose 2-bit output (01 / 10) returns here as `jogador`.

Parameters:
N_CASAS, 9, number of board cells (fixed 3x3; row-major, index 0 = top-left, 8 = bottom-right)

Ports:
clk  input  1  system clock, all state updates on rising edge
clear_n  input  1  asynchronous active-low reset
novo_jogo  input  1  synchronous new-game clear; priority over all other inputs
jogador  input  2  current player code from turn flip-flop: 01 or 10; 00/11 illegal
jogada_valid  input  1  move request present
jogada_pos  input  4  requested cell index 0..8
jogada_ready  output  1  controller can accept a move
troca_jogador  output  1  one-cycle pulse to turn flip-flop T input
jogada_invalida  output  1  one-cycle pulse: rejected move
tabuleiro  output  18  board; cell i = bits [2i+1:2i], 00 empty, else player code
vencedor  output  2  winning player code, 00 = none
empate  output  1  draw flag
fim_jogo  output  1  game over (win or draw)

Behaviour:
- Reset, asynchronous on `clear_n` low:
  - Board, move counter, latched pos/player, `vencedor`, `empate` and `fim_jogo` all go to 0.
  - State goes to ESPERA, so `jogada_ready` = 1 and both pulse outputs = 0.
- `novo_jogo` = 1 at an edge: same effect as reset, from any state, overriding any transition or handshake in that cycle.
  - The top level also routes `novo_jogo` to the turn flip-flop clear.
- States: ESPERA, VERIFICA, ESCREVE, AVALIA, TROCA, INVALIDA, FIM.
- Moore outputs:
  - `jogada_ready` = (state == ESPERA).
  - `troca_jogador` = (state == TROCA).
  - `jogada_invalida` = (state == INVALIDA).
- ESPERA: on an edge with `jogada_valid` & `jogada_ready` (E0), latch `jogada_pos` and `jogador`, then go to VERIFICA. No accept in any other state.
- VERIFICA (E1):
  - Go to INVALIDA if any of these holds: latched pos > 8, addressed cell != 00, or latched player code is 00/11.
  - Otherwise go to ESCREVE.
- INVALIDA: one cycle, then ESPERA. Board, counter and turn are unchanged.
- ESCREVE (E2): write the latched player code into the cell, increment the move counter (4-bit, range 0..9), go to AVALIA.
- AVALIA (E3): evaluate the 8 lines (3 rows, 3 columns, 2 diagonals) on the updated board for three cells equal to the latched player.
  - Win: register `vencedor` = player and `fim_jogo` = 1, go to FIM.
  - Else, if counter == 9: `empate` = 1, `fim_jogo` = 1, go to FIM.
  - Else go to TROCA.
  - A win on the 9th move is a win, not a draw.
- TROCA: `troca_jogador` is high for exactly one cycle; the flip-flop toggles at E4. The state returns to ESPERA at E4.
  - Ready therefore reasserts only after `jogador` has already updated.
- FIM: `jogada_ready` = 0; requests are ignored with no invalid pulse. Outputs hold until `novo_jogo` or reset.
- Latency from accept edge E0:
  - Board visible after E2.
  - `vencedor`/`empate`/`fim_jogo` visible after E3.
  - `troca_jogador` high in cycle E3–E4; ready again after E4.
  - Rejected move: `jogada_invalida` high in cycle E1–E2, ready again after E2.
- `jogada_valid` held high across several cycles: only the edge where ready = 1 counts; the source must deassert or present a new move.
- `tabuleiro` is a direct register output; the board is never altered except by ESCREVE, reset or `novo_jogo`.

Test Plan:
- Reset, then `jogador`=01 and pos 4 accepted → after E2, `tabuleiro[9:8]`=01; `troca_jogador` pulses 1 cycle after E3; ready returns after E4; no invalid pulse.
- Pos 4 again with `jogador`=10 (occupied), then pos 12 (out of range) → `jogada_invalida` 1-cycle pulse each time; board unchanged; no `troca_jogador`.
- Player 01 takes 0,1,2 interleaved with 10 on 3,4 → after the move on cell 2: `vencedor`=01, `fim_jogo`=1, no toggle pulse, ready held 0; a later valid request is ignored.
- Full-board sequence 0,1,2,4,3,5,7,6,8 with alternating 01/10 → after move 9: `empate`=1, `vencedor`=00, `fim_jogo`=1.
- Diagonal win for 10 (cells 2,4,6) completed on the 9th move → `vencedor`=10, `empate`=0.
- `clear_n` pulsed low mid-ESCREVE, and separately `novo_jogo` asserted in TROCA and in FIM → board=0, counter=0, flags=0, state ESPERA, ready=1, no stray pulses.
